demux1_2_stream: RTL and testbench

Registered 1-to-2 stream demultiplexer with valid/ready handshaking. One input stream is steered word-by-word to output A or output B by a per-word select bit. Each output has its own Depth-entry FIFO, so a stalled consumer on one side only blocks input words destined for that side. The block is the distribution counterpart of the team's registered 2:1 selection path and sits between a single producer and two independent consumers.

---
 rtl/demux1_2_stream.sv | 96 +++++++++
 tb/tb_demux1_2_stream.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/demux1_2_stream.sv
// demux1_2_stream
// Registered 1-to-2 stream demultiplexer. Each input word is steered by
// s_sel_i into one of two independent FIFOs (A = 0, B = 1), so a stalled
// consumer only blocks words headed for its own side. Outputs come straight
// from FIFO state, so there is no combinational path from input to output.
module demux1_2_stream #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic                         s_sel_i,
    input  logic [Width-1:0]             s_data_i,
    output logic                         a_valid_o,
    input  logic                         a_ready_i,
    output logic [Width-1:0]             a_data_o,
    output logic [$clog2(Depth+1)-1:0]   a_count_o,
    output logic                         b_valid_o,
    input  logic                         b_ready_i,
    output logic [Width-1:0]             b_data_o,
    output logic [$clog2(Depth+1)-1:0]   b_count_o
);

    localparam int CW = $clog2(Depth + 1);
    localparam int PW = $clog2(Depth);
    localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

    // Per-side views; index 0 is output A, index 1 is output B.
    logic [1:0]       x_ready;
    logic [1:0]       x_full;
    logic [1:0]       x_valid;
    logic [1:0]       x_push;
    logic [1:0]       x_pop;
    logic [Width-1:0] x_data  [2];
    logic [CW-1:0]    x_count [2];

    assign x_ready = {b_ready_i, a_ready_i};

    // Ready depends only on the selected side's registered full flag: a full
    // FIFO refuses input even if its consumer pops this same cycle.
    assign s_ready_o = s_sel_i ? !x_full[1] : !x_full[0];

    assign x_push[0] = s_valid_i && s_ready_o && !s_sel_i;
    assign x_push[1] = s_valid_i && s_ready_o &&  s_sel_i;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [Width-1:0] mem_q [Depth];
        logic [PW-1:0]    wr_ptr_q;
        logic [PW-1:0]    rd_ptr_q;
        logic [CW-1:0]    cnt_q;

        assign x_valid[g] = (cnt_q != '0);
        assign x_full[g]  = (cnt_q == FULL_CNT);
        assign x_pop[g]   = x_valid[g] && x_ready[g];
        assign x_data[g]  = mem_q[rd_ptr_q];
        assign x_count[g] = cnt_q;

        // Storage and write pointer: accepted words land at the write pointer.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                mem_q    <= '{default: '0};
                wr_ptr_q <= '0;
            end else if (x_push[g]) begin
                mem_q[wr_ptr_q] <= s_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
        end

        // Read pointer and occupancy: push and pop together leave count alone.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (x_pop[g]) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                case ({x_push[g], x_pop[g]})
                    2'b10:   cnt_q <= cnt_q + CW'(1);
                    2'b01:   cnt_q <= cnt_q - CW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    assign a_valid_o = x_valid[0];
    assign a_data_o  = x_data[0];
    assign a_count_o = x_count[0];
    assign b_valid_o = x_valid[1];
    assign b_data_o  = x_data[1];
    assign b_count_o = x_count[1];

endmodule

// File: tb/tb_demux1_2_stream.sv
// Testbench for demux1_2_stream: per-output scoreboard queues filled when a
// word is accepted and drained when the consumer pops it.
module tb_demux1_2_stream;

    localparam int Width = 8;
    localparam int Depth = 2;
    localparam int CW    = $clog2(Depth + 1);

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             s_valid_i = 1'b0;
    logic             s_ready_o;
    logic             s_sel_i = 1'b0;
    logic [Width-1:0] s_data_i = '0;
    logic             a_valid_o;
    logic             a_ready_i = 1'b0;
    logic [Width-1:0] a_data_o;
    logic [CW-1:0]    a_count_o;
    logic             b_valid_o;
    logic             b_ready_i = 1'b0;
    logic [Width-1:0] b_data_o;
    logic [CW-1:0]    b_count_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [Width-1:0] qa[$];
    logic [Width-1:0] qb[$];

    demux1_2_stream #(.Width(Width), .Depth(Depth)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_sel_i   (s_sel_i),
        .s_data_i  (s_data_i),
        .a_valid_o (a_valid_o),
        .a_ready_i (a_ready_i),
        .a_data_o  (a_data_o),
        .a_count_o (a_count_o),
        .b_valid_o (b_valid_o),
        .b_ready_i (b_ready_i),
        .b_data_o  (b_data_o),
        .b_count_o (b_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive on the falling edge, check against the model,
    // then commit the transfers the model predicts at the rising edge.
    task automatic cycle(input logic v, input logic sel, input logic [Width-1:0] d,
                         input logic ar, input logic br, output logic accepted);
        logic exp_rdy;
        logic pop_a;
        logic pop_b;
        @(negedge clk_i);
        s_valid_i = v;
        s_sel_i   = sel;
        s_data_i  = d;
        a_ready_i = ar;
        b_ready_i = br;
        #1;
        exp_rdy = sel ? (qb.size() < Depth) : (qa.size() < Depth);
        chk("s_ready", s_ready_o, exp_rdy);
        chk("a_count", a_count_o, qa.size());
        chk("b_count", b_count_o, qb.size());
        chk("a_valid", a_valid_o, qa.size() != 0);
        chk("b_valid", b_valid_o, qb.size() != 0);
        if (qa.size() != 0) chk("a_data", a_data_o, qa[0]);
        if (qb.size() != 0) chk("b_data", b_data_o, qb[0]);
        pop_a    = ar && (qa.size() != 0);
        pop_b    = br && (qb.size() != 0);
        accepted = v && exp_rdy;
        @(posedge clk_i);
        if (pop_a) void'(qa.pop_front());
        if (pop_b) void'(qb.pop_front());
        if (accepted) begin
            if (sel) qb.push_back(d);
            else     qa.push_back(d);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        logic hold_v;
        logic hold_sel;
        logic [Width-1:0] hold_d;
        logic [Width-1:0] a_snap;

        // Reset state while rst_i is held.
        #12;
        chk("rst_a_valid", a_valid_o, 0);
        chk("rst_b_valid", b_valid_o, 0);
        chk("rst_a_data", a_data_o, 0);
        chk("rst_b_data", b_data_o, 0);
        chk("rst_a_count", a_count_o, 0);
        chk("rst_b_count", b_count_o, 0);
        chk("rst_s_ready", s_ready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Steering with both consumers ready.
        cycle(1'b1, 1'b0, 8'h11, 1'b1, 1'b1, acc);
        cycle(1'b1, 1'b1, 8'h22, 1'b1, 1'b1, acc);
        cycle(1'b1, 1'b0, 8'h33, 1'b1, 1'b1, acc);
        idle(3);

        // Fill A with consumer A stalled; third word must be refused.
        cycle(1'b1, 1'b0, 8'hA0, 1'b0, 1'b1, acc);
        cycle(1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, acc);
        cycle(1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, acc);
        chk("full_refuse", acc, 0);
        cycle(1'b1, 1'b0, 8'hA2, 1'b1, 1'b1, acc);
        chk("no_pop_through", acc, 0);
        cycle(1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, acc);
        chk("resume_after_pop", acc, 1);

        // Independence: A full and stalled, B still flows.
        a_snap = a_data_o;
        cycle(1'b1, 1'b1, 8'h5B, 1'b0, 1'b0, acc);
        chk("b_indep_accept", acc, 1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("b_indep_data", b_data_o, 8'h5B);
        chk("a_unchanged", a_data_o, a_snap);
        idle(4);

        // Simultaneous push/pop on A with one word resident.
        cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, acc);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(i), 1'b1, 1'b1, acc);
        idle(3);

        // Asynchronous reset mid-cycle with two words buffered in A.
        cycle(1'b1, 1'b0, 8'h71, 1'b0, 1'b0, acc);
        cycle(1'b1, 1'b0, 8'h72, 1'b0, 1'b0, acc);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        chk("pre_rst_a_count", a_count_o, 2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_a_valid", a_valid_o, 0);
        chk("async_a_count", a_count_o, 0);
        chk("async_a_data", a_data_o, 0);
        qa.delete();
        qb.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        s_sel_i = 1'b0;
        #1;
        chk("post_rst_ready_a", s_ready_o, 1);
        s_sel_i = 1'b1;
        #1;
        chk("post_rst_ready_b", s_ready_o, 1);

        // Random traffic; stalled words are held until accepted.
        hold_v = 1'b0;
        hold_sel = 1'b0;
        hold_d = '0;
        for (int i = 0; i < 10000; i++) begin
            logic v;
            logic sel;
            logic [Width-1:0] d;
            if (hold_v) begin
                v = 1'b1;
                sel = hold_sel;
                d = hold_d;
            end else begin
                v   = ($urandom_range(0, 3) != 0);
                sel = 1'($urandom_range(0, 1));
                d   = 8'($urandom_range(0, 255));
            end
            cycle(v, sel, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), acc);
            hold_v   = v && !acc;
            hold_sel = sel;
            hold_d   = d;
        end
        idle(6);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
